// File: rtl/mem_wr_fifo_if.sv
// Bundle between the write-back stage, the data cache and the store write FIFO.
// The master drives pushes, the pending load and completion; the slave is the FIFO.
interface mem_wr_fifo_if;
    logic        wb_push;
    logic [31:0] wb_addr;
    logic [63:0] wb_data;
    logic [1:0]  wb_size;
    logic [31:0] mem_rd_addr;
    logic [1:0]  mem_rd_size;
    logic        mem_wr_done;
    logic [31:0] mem_wr_addr;
    logic [63:0] mem_wr_data;
    logic [1:0]  mem_wr_size;
    logic        wr_fifo_empty;
    logic        wr_fifo_to_be_full;
    logic        wr_fifo_full;
    logic        mem_conflict;
    logic        wr_fifo_ovf;

    modport master (
        output wb_push, wb_addr, wb_data, wb_size, mem_rd_addr, mem_rd_size, mem_wr_done,
        input  mem_wr_addr, mem_wr_data, mem_wr_size, wr_fifo_empty, wr_fifo_to_be_full,
               wr_fifo_full, mem_conflict, wr_fifo_ovf
    );

    modport slave (
        input  wb_push, wb_addr, wb_data, wb_size, mem_rd_addr, mem_rd_size, mem_wr_done,
        output mem_wr_addr, mem_wr_data, mem_wr_size, wr_fifo_empty, wr_fifo_to_be_full,
               wr_fifo_full, mem_conflict, wr_fifo_ovf
    );
endinterface

// File: rtl/mem_wr_fifo.sv
// Store write buffer between write-back and the data cache: circular FIFO of retired
// stores with a 16-byte line conflict check against the pending load.
module mem_wr_fifo #(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    mem_wr_fifo_if.slave  bus
);
    localparam int              AW       = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]     CNT_ZERO = (AW+1)'(0);
    localparam logic [AW:0]     CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]     CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]     CNT_TBF  = (AW+1)'(DEPTH - 1);
    localparam logic [AW-1:0]   PTR_ZERO = AW'(0);
    localparam logic [AW-1:0]   PTR_ONE  = AW'(1);

    logic [31:0]   addr_r [DEPTH];
    logic [63:0]   data_r [DEPTH];
    logic [1:0]    size_r [DEPTH];
    logic [AW-1:0] head_r;
    logic [AW-1:0] tail_r;
    logic [AW:0]   count_r;
    logic          ovf_r;

    logic          empty_s;
    logic          full_s;
    logic          to_be_full_s;
    logic          push_s;
    logic          pop_s;
    logic          drop_s;
    logic [31:0]   head_addr_s;
    logic [63:0]   head_data_s;
    logic [1:0]    head_size_s;
    logic [27:0]   ld_first_s;
    logic [27:0]   ld_last_s;
    logic          conflict_s;

    // Line index of the first (last=0) or last (last=1) byte touched by an access;
    // the 32-bit carry out of the end-address sum is deliberately dropped.
    function automatic logic [27:0] line_of(input logic [31:0] addr, input logic [1:0] size,
                                            input logic last);
        logic [31:0] off;
        logic [31:0] byte_addr;
        off = 32'd0;
        if (last) begin
            case (size)
                2'd0:    off = 32'd0;
                2'd1:    off = 32'd1;
                2'd2:    off = 32'd3;
                2'd3:    off = 32'd7;
                default: off = 32'd0;
            endcase
        end else begin
            off = 32'd0;
        end
        byte_addr = addr + off;
        return byte_addr[31:4];
    endfunction

    // Occupancy flags and handshake qualification
    always_comb begin
        empty_s      = (count_r == CNT_ZERO);
        full_s       = (count_r == CNT_FULL);
        to_be_full_s = (count_r >= CNT_TBF);
        push_s       = bus.wb_push & (~full_s | bus.mem_wr_done);
        pop_s        = bus.mem_wr_done & ~empty_s;
        drop_s       = bus.wb_push & full_s & ~bus.mem_wr_done;
    end

    // Pointers, occupancy and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r  <= PTR_ZERO;
            tail_r  <= PTR_ZERO;
            count_r <= CNT_ZERO;
            ovf_r   <= 1'b0;
        end else begin
            if (push_s) tail_r <= tail_r + PTR_ONE;
            if (pop_s)  head_r <= head_r + PTR_ONE;
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
            if (drop_s) ovf_r <= 1'b1;
        end
    end

    // Entry storage; contents are left stale on reset since validity comes from the pointers
    always_ff @(posedge clk) begin
        if (!rst && push_s) begin
            addr_r[tail_r] <= bus.wb_addr;
            data_r[tail_r] <= bus.wb_data;
            size_r[tail_r] <= bus.wb_size;
        end
    end

    // Head entry presentation, forced to zero while nothing is buffered
    always_comb begin
        if (empty_s) begin
            head_addr_s = 32'd0;
            head_data_s = 64'd0;
            head_size_s = 2'd0;
        end else begin
            head_addr_s = addr_r[head_r];
            head_data_s = data_r[head_r];
            head_size_s = size_r[head_r];
        end
    end

    // Load/store line overlap; a slot is live when its distance from head is below occupancy
    always_comb begin
        ld_first_s = line_of(bus.mem_rd_addr, bus.mem_rd_size, 1'b0);
        ld_last_s  = line_of(bus.mem_rd_addr, bus.mem_rd_size, 1'b1);
        conflict_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (({1'b0, AW'(i) - head_r} < count_r) &&
                ((line_of(addr_r[i], size_r[i], 1'b0) == ld_first_s) ||
                 (line_of(addr_r[i], size_r[i], 1'b0) == ld_last_s)  ||
                 (line_of(addr_r[i], size_r[i], 1'b1) == ld_first_s) ||
                 (line_of(addr_r[i], size_r[i], 1'b1) == ld_last_s))) begin
                conflict_s = 1'b1;
            end else begin
                conflict_s = conflict_s;
            end
        end
    end

    assign bus.mem_wr_addr        = head_addr_s;
    assign bus.mem_wr_data        = head_data_s;
    assign bus.mem_wr_size        = head_size_s;
    assign bus.wr_fifo_empty      = empty_s;
    assign bus.wr_fifo_to_be_full = to_be_full_s;
    assign bus.wr_fifo_full       = full_s;
    assign bus.mem_conflict       = conflict_s;
    assign bus.wr_fifo_ovf        = ovf_r;
endmodule

// File: tb/tb_mem_wr_fifo.sv
// Directed bench for mem_wr_fifo: queue-based reference model checked every cycle,
// plus literal expectations at the key scenario points.
module tb_mem_wr_fifo;
    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] a;
        logic [63:0] d;
        logic [1:0]  s;
    } ent_t;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    bit   model_valid;
    bit   m_ovf;
    ent_t q[$];

    mem_wr_fifo_if bus ();

    mem_wr_fifo #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Two accesses clash when any boundary line of one equals any boundary line of the other
    function automatic bit lines_clash(logic [31:0] ea, logic [1:0] es, logic [31:0] la, logic [1:0] ls);
        logic [31:0] e_lo, e_hi, l_lo, l_hi;
        e_lo = ea >> 4;
        e_hi = (ea + (32'd1 << es) - 32'd1) >> 4;
        l_lo = la >> 4;
        l_hi = (la + (32'd1 << ls) - 32'd1) >> 4;
        return (e_lo == l_lo) || (e_lo == l_hi) || (e_hi == l_lo) || (e_hi == l_hi);
    endfunction

    task automatic check_outputs();
        bit exp_conf;
        exp_conf = 1'b0;
        foreach (q[i]) if (lines_clash(q[i].a, q[i].s, bus.mem_rd_addr, bus.mem_rd_size)) exp_conf = 1'b1;
        chk("head_addr", 64'(bus.mem_wr_addr), (q.size() > 0) ? 64'(q[0].a) : 64'd0);
        chk("head_data", bus.mem_wr_data, (q.size() > 0) ? q[0].d : 64'd0);
        chk("head_size", 64'(bus.mem_wr_size), (q.size() > 0) ? 64'(q[0].s) : 64'd0);
        chk("empty", 64'(bus.wr_fifo_empty), 64'(q.size() == 0));
        chk("to_be_full", 64'(bus.wr_fifo_to_be_full), 64'(q.size() >= DEPTH - 1));
        chk("full", 64'(bus.wr_fifo_full), 64'(q.size() == DEPTH));
        chk("conflict", 64'(bus.mem_conflict), 64'(exp_conf));
        chk("ovf", 64'(bus.wr_fifo_ovf), 64'(m_ovf));
    endtask

    task automatic model_edge();
        bit pop, push;
        ent_t e;
        if (rst) begin
            q.delete();
            m_ovf = 1'b0;
            model_valid = 1'b1;
        end else begin
            pop  = bus.mem_wr_done && (q.size() > 0);
            push = bus.wb_push && ((q.size() < DEPTH) || bus.mem_wr_done);
            if (bus.wb_push && (q.size() == DEPTH) && !bus.mem_wr_done) m_ovf = 1'b1;
            if (pop) void'(q.pop_front());
            if (push) begin
                e.a = bus.wb_addr;
                e.d = bus.wb_data;
                e.s = bus.wb_size;
                q.push_back(e);
            end
        end
    endtask

    // One clock: compare mid-cycle, advance the model on the edge, return just after it
    task automatic cycle();
        @(negedge clk);
        if (model_valid) check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_push(input bit p, input logic [31:0] a, input logic [63:0] d, input logic [1:0] s);
        bus.wb_push = p;
        bus.wb_addr = a;
        bus.wb_data = d;
        bus.wb_size = s;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        model_valid = 1'b0;
        m_ovf = 1'b0;
        rst = 1'b1;
        set_push(1'b0, 32'd0, 64'd0, 2'd0);
        bus.mem_rd_addr = 32'h0000_8000;
        bus.mem_rd_size = 2'd0;
        bus.mem_wr_done = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
        chk("lit_reset_empty", 64'(bus.wr_fifo_empty), 64'd1);
        chk("lit_reset_head", 64'(bus.mem_wr_addr), 64'd0);

        // Two pushes, head visible one cycle after the first
        set_push(1'b1, 32'h0000_1000, 64'h1122_3344, 2'd2);
        cycle();
        chk("lit_head_addr", 64'(bus.mem_wr_addr), 64'h1000);
        chk("lit_head_data", bus.mem_wr_data, 64'h1122_3344);
        chk("lit_not_empty", 64'(bus.wr_fifo_empty), 64'd0);
        set_push(1'b1, 32'h0000_2008, 64'h5566_7788_99AA_BBCC, 2'd3);
        cycle();
        chk("lit_tbf_at2", 64'(bus.wr_fifo_to_be_full), 64'd0);

        // Fill to full, then an overflowing push
        set_push(1'b1, 32'h0000_3000, 64'h0000_0000_0000_BEEF, 2'd1);
        cycle();
        chk("lit_tbf_at3", 64'(bus.wr_fifo_to_be_full), 64'd1);
        chk("lit_full_at3", 64'(bus.wr_fifo_full), 64'd0);
        set_push(1'b1, 32'h0000_4001, 64'h0000_0000_0000_00A5, 2'd0);
        cycle();
        chk("lit_full_at4", 64'(bus.wr_fifo_full), 64'd1);
        set_push(1'b1, 32'h0000_5000, 64'hDEAD, 2'd2);
        cycle();
        chk("lit_ovf_set", 64'(bus.wr_fifo_ovf), 64'd1);
        chk("lit_head_kept", 64'(bus.mem_wr_addr), 64'h1000);
        set_push(1'b0, 32'd0, 64'd0, 2'd0);
        cycle();
        chk("lit_ovf_sticky", 64'(bus.wr_fifo_ovf), 64'd1);

        // Fresh fill, then six push-with-pop cycles wrap both pointers
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            set_push(1'b1, 32'h0000_6000 + 32'(i * 16), 64'(i + 100), 2'(i));
            cycle();
        end
        for (int i = 0; i < 6; i++) begin
            set_push(1'b1, 32'h0000_3000 + 32'(i * 16), 64'(i + 200), 2'd3);
            bus.mem_wr_done = 1'b1;
            cycle();
        end
        set_push(1'b0, 32'd0, 64'd0, 2'd0);
        bus.mem_wr_done = 1'b0;
        chk("lit_wrap_full", 64'(bus.wr_fifo_full), 64'd1);
        chk("lit_wrap_ovf", 64'(bus.wr_fifo_ovf), 64'd0);
        chk("lit_wrap_head", 64'(bus.mem_wr_addr), 64'h3020);

        // Drain, plus one done pulse on an empty FIFO
        bus.mem_wr_done = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) cycle();
        bus.mem_wr_done = 1'b0;
        chk("lit_drained", 64'(bus.wr_fifo_empty), 64'd1);

        // Push while empty with a matching load: the in-flight entry must not conflict
        bus.mem_rd_addr = 32'h0000_1010;
        bus.mem_rd_size = 2'd0;
        set_push(1'b1, 32'h0000_100E, 64'h1234, 2'd2);
        #1;
        chk("lit_conf_inflight", 64'(bus.mem_conflict), 64'd0);
        cycle();
        set_push(1'b0, 32'd0, 64'd0, 2'd0);
        #1;
        chk("lit_conf_line_end", 64'(bus.mem_conflict), 64'd1);
        bus.mem_rd_addr = 32'h0000_1020;
        bus.mem_rd_size = 2'd3;
        #1;
        chk("lit_conf_far", 64'(bus.mem_conflict), 64'd0);
        bus.mem_rd_addr = 32'h0000_1004;
        bus.mem_rd_size = 2'd1;
        bus.mem_wr_done = 1'b1;
        #1;
        chk("lit_conf_popping", 64'(bus.mem_conflict), 64'd1);
        cycle();
        bus.mem_wr_done = 1'b0;
        #1;
        chk("lit_conf_popped", 64'(bus.mem_conflict), 64'd0);
        cycle();

        // Reset with three entries and a simultaneous push
        for (int i = 0; i < 3; i++) begin
            set_push(1'b1, 32'h0000_7000 + 32'(i * 8), 64'(i + 300), 2'd3);
            cycle();
        end
        bus.mem_rd_addr = 32'h0000_7000;
        rst = 1'b1;
        set_push(1'b1, 32'h0000_7100, 64'h77, 2'd0);
        cycle();
        rst = 1'b0;
        set_push(1'b0, 32'd0, 64'd0, 2'd0);
        chk("lit_rst_empty", 64'(bus.wr_fifo_empty), 64'd1);
        chk("lit_rst_conf", 64'(bus.mem_conflict), 64'd0);
        cycle();
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_wr_fifo.md
MEM_WR_FIFO -- requirements
Module: mem_wr_fifo

Interface
REQ-001 Parameter DEPTH, default 4; number of store entries (power of two, >= 2).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 wb_push  input  1  write-back stage presents a retiring store this cycle.
REQ-005 wb_addr  input  32  store virtual byte address.
REQ-006 wb_data  input  64  store data, right-aligned.
REQ-007 wb_size  input  2  store size code: 0=1B, 1=2B, 2=4B, 3=8B.
REQ-008 mem_rd_addr  input  32  pending read-operand load address.
REQ-009 mem_rd_size  input  2  pending load size code, same encoding.
REQ-010 mem_wr_done  input  1  data cache has completed the head store (one-cycle pulse).
REQ-011 mem_wr_addr  output  32  head entry address.
REQ-012 mem_wr_data  output  64  head entry data.
REQ-013 mem_wr_size  output  2  head entry size.
REQ-014 wr_fifo_empty  output  1  no valid entries.
REQ-015 wr_fifo_to_be_full  output  1  occupancy >= DEPTH-1.
REQ-016 wr_fifo_full  output  1  occupancy == DEPTH; write-back stage stalls on it.
REQ-017 mem_conflict  output  1  pending load overlaps a buffered store line.
REQ-018 wr_fifo_ovf  output  1  sticky error: push attempted while full without a same-cycle pop.

Function
REQ-019 Storage: DEPTH entries of {addr, data, size}; head pointer, tail pointer, occupancy counter of width log2(DEPTH)+1.
REQ-020 Push accepted when wb_push & (!wr_fifo_full | mem_wr_done); entry written at tail, tail advances modulo DEPTH.
REQ-021 Pop occurs when mem_wr_done & !wr_fifo_empty; head advances modulo DEPTH.
REQ-022 mem_wr_done while empty: ignored, no pointer or count change.
REQ-023 Simultaneous accepted push and pop: occupancy unchanged, both pointers advance.
REQ-024 Push while full without pop: entry dropped, state unchanged, wr_fifo_ovf set on the next edge and held until rst.
REQ-025 Occupancy: +1 on push only, -1 on pop only; never exceeds DEPTH or drops below 0.
REQ-026 Pointer wrap: pointer at DEPTH-1 advances to 0.
REQ-027 Head outputs: mem_wr_addr/data/size driven combinationally from the head entry; when empty they are 0.
REQ-028 Latency: a store pushed into an empty FIFO appears on head outputs, with wr_fifo_empty=0, the cycle after the push edge (1 cycle).
REQ-029 Flags wr_fifo_empty, wr_fifo_to_be_full and wr_fifo_full are decoded combinationally from the registered occupancy.
REQ-030 Byte span: an access covers [addr, addr+N-1] with N=1,2,4,8 per size code; start line = addr[31:4], end line = (addr+N-1)[31:4], 32-bit wrap-around ignored (carry discarded).
REQ-031 mem_conflict = 1 when any valid entry's start line or end line equals the load's start line or end line; otherwise 0.
REQ-032 mem_conflict is combinational and evaluated against pre-edge contents; an entry being pushed this cycle does not participate, and an entry being popped this cycle still participates.
REQ-033 Invalid (empty) slots never contribute to mem_conflict, regardless of stale contents.

Reset
REQ-034 rst=1 at a rising edge: head=tail=0, occupancy=0, wr_fifo_ovf=0, wr_fifo_empty=1, wr_fifo_to_be_full=0, wr_fifo_full=0, mem_conflict=0, head outputs 0.
REQ-035 Reset takes priority over simultaneous push/pop; in-flight entries are discarded; entry storage need not be cleared.

Verification
REQ-036 Push 0x1000/0x11223344/size2, then push 0x2008/size3 -> head shows 0x1000 one cycle after the first push; occupancy 2; empty=0, to_be_full=0.
REQ-037 Fill 4 entries (DEPTH=4) -> to_be_full=1 at 3 entries, full=1 at 4; a 5th push without done -> entry dropped, ovf=1 sticky; head unchanged.
REQ-038 Full FIFO, push 0x3000 with mem_wr_done -> occupancy stays 4, old head popped, 0x3000 at tail; ovf stays 0; pointers wrap to 0 correctly across 6 push/pop cycles.
REQ-039 Store at 0x100E size2 (lines 0x100, 0x101) buffered; load 0x1010 size0 -> mem_conflict=1; load 0x1020 size3 -> 0; after pop -> 0.
REQ-040 mem_wr_done on empty FIFO -> no change, empty stays 1; assert rst with 3 entries plus simultaneous push -> next cycle occupancy 0, empty=1, mem_conflict=0.
